// File: rtl/aes_pkg.sv
// Shared definitions for the AES SPI sequencer: key-size codes, error codes,
// header layout and FSM state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b01,
        KEY_256 = 2'b10,
        KEY_ILL = 2'b11
    } key_sel_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_KEY     = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    localparam int MODE_BIT = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_TX_ISSUE,
        S_TX_WAIT,
        S_RES_WAIT,
        S_RX_ISSUE,
        S_RX_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [5:0] kb_of(input logic [1:0] sel);
        case (sel)
            KEY_128: kb_of = 6'd16;
            KEY_192: kb_of = 6'd24;
            KEY_256: kb_of = 6'd32;
            default: kb_of = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_frame_mux.sv
// Selects the outgoing frame byte: block bytes MSB first, then the header,
// then the active key bytes from the most significant active byte down.
module aes_frame_mux
    import aes_pkg::*;
#(
    parameter int BLOCK_BYTES   = 16,
    parameter int MAX_KEY_BYTES = 32
) (
    input  logic [5:0]                 i_idx,
    input  logic [8*BLOCK_BYTES-1:0]   i_block,
    input  logic [7:0]                 i_header,
    input  logic [8*MAX_KEY_BYTES-1:0] i_key,
    input  logic [5:0]                 i_kb,
    output logic [7:0]                 o_byte
);

    logic [5:0] w_kpos;

    // Key byte position counted from the LSB of the right-aligned key.
    assign w_kpos = i_kb + 6'(BLOCK_BYTES) - i_idx;

    always_comb begin
        o_byte = 8'h00;
        if (i_idx < 6'(BLOCK_BYTES)) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (i_idx == 6'(i)) o_byte = i_block[8*(BLOCK_BYTES-1-i) +: 8];
            end
        end else if (i_idx == 6'(BLOCK_BYTES)) begin
            o_byte = i_header;
        end else begin
            for (int i = 0; i < MAX_KEY_BYTES; i++) begin
                if (w_kpos == 6'(i)) o_byte = i_key[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/aes_spi_sequencer.sv
// Host-side sequencer: frames block+header+key out through a byte SPI master,
// waits for the slave result flag, then clocks the result block back in.
//
// state      | meaning
// S_IDLE     | waiting for req
// S_LOAD     | load byte counters
// S_TX_ISSUE | start next frame byte once the master is free
// S_TX_WAIT  | wait for the byte to complete
// S_RES_WAIT | wait for slave result-ready, with timeout
// S_RX_ISSUE | start a dummy byte to clock a result byte in
// S_RX_WAIT  | wait for the result byte
// S_DONE     | compare and report completion
// S_ERR      | report an error completion
module aes_spi_sequencer
    import aes_pkg::*;
#(
    parameter int BLOCK_BYTES    = 16,
    parameter int MAX_KEY_BYTES  = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         mode,
    input  logic [1:0]                   key_sel,
    input  logic [8*BLOCK_BYTES-1:0]     block_in,
    input  logic [8*MAX_KEY_BYTES-1:0]   key_in,
    input  logic [8*BLOCK_BYTES-1:0]     expected_in,
    input  logic                         cmp_en,
    output logic                         spi_start,
    output logic [7:0]                   spi_tx,
    input  logic                         spi_busy,
    input  logic                         spi_done,
    input  logic [7:0]                   spi_rx,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         done,
    output logic [8*BLOCK_BYTES-1:0]     result,
    output logic                         match,
    output logic [1:0]                   err
);

    localparam int              TW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [5:0]      TX_BASE = 6'(BLOCK_BYTES + 1);
    localparam logic [4:0]      RX_LOAD = 5'(BLOCK_BYTES);

    state_e                        r_state, w_next_state;
    logic [8*BLOCK_BYTES-1:0]      r_block, r_expected, r_result;
    logic [8*MAX_KEY_BYTES-1:0]    r_key;
    logic                          r_mode, r_cmp_en;
    logic [1:0]                    r_key_sel, r_err;
    logic [5:0]                    r_tx_cnt;
    logic [4:0]                    r_rx_cnt;
    logic [TW-1:0]                 r_to_cnt;
    logic                          r_spi_start, r_busy, r_done, r_match;
    logic [7:0]                    r_spi_tx;

    logic [5:0] w_kb, w_tx_len, w_tx_idx;
    logic [7:0] w_header, w_tx_byte;
    logic       w_timeout;

    assign w_kb      = kb_of(r_key_sel);
    assign w_tx_len  = w_kb + TX_BASE;
    assign w_tx_idx  = w_tx_len - r_tx_cnt;
    assign w_header  = 8'(w_kb) | (8'(r_mode) << MODE_BIT);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TW'(1));

    aes_frame_mux #(
        .BLOCK_BYTES  (BLOCK_BYTES),
        .MAX_KEY_BYTES(MAX_KEY_BYTES)
    ) u_frame_mux (
        .i_idx   (w_tx_idx),
        .i_block (r_block),
        .i_header(w_header),
        .i_key   (r_key),
        .i_kb    (w_kb),
        .o_byte  (w_tx_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (req) w_next_state = (key_sel == KEY_ILL) ? S_ERR : S_LOAD;
            S_LOAD:     w_next_state = S_TX_ISSUE;
            S_TX_ISSUE: if (!spi_busy) w_next_state = S_TX_WAIT;
            S_TX_WAIT:  if (spi_done) w_next_state = (r_tx_cnt == 6'd1) ? S_RES_WAIT : S_TX_ISSUE;
            S_RES_WAIT: begin
                if (res_ready)      w_next_state = S_RX_ISSUE;
                else if (w_timeout) w_next_state = S_ERR;
            end
            S_RX_ISSUE: if (!spi_busy) w_next_state = S_RX_WAIT;
            S_RX_WAIT:  if (spi_done) w_next_state = (r_rx_cnt == 5'd1) ? S_DONE : S_RX_ISSUE;
            S_DONE:     w_next_state = S_IDLE;
            S_ERR:      w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_block     <= '0;
            r_key       <= '0;
            r_expected  <= '0;
            r_result    <= '0;
            r_mode      <= 1'b0;
            r_cmp_en    <= 1'b0;
            r_key_sel   <= 2'b00;
            r_err       <= ERR_OK;
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_to_cnt    <= '0;
            r_spi_start <= 1'b0;
            r_spi_tx    <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: if (req) begin
                    r_block    <= block_in;
                    r_key      <= key_in;
                    r_mode     <= mode;
                    r_key_sel  <= key_sel;
                    r_expected <= expected_in;
                    r_cmp_en   <= cmp_en;
                    r_match    <= 1'b0;
                    if (key_sel == KEY_ILL) begin
                        r_err <= ERR_KEY;
                    end else begin
                        r_err  <= ERR_OK;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_tx_cnt <= w_tx_len;
                    r_rx_cnt <= RX_LOAD;
                end
                S_TX_ISSUE: if (!spi_busy) begin
                    r_spi_start <= 1'b1;
                    r_spi_tx    <= w_tx_byte;
                end
                S_TX_WAIT: if (spi_done) begin
                    r_tx_cnt <= r_tx_cnt - 6'd1;
                    r_to_cnt <= TO_LOAD;
                end
                S_RES_WAIT: if (!res_ready) begin
                    r_to_cnt <= r_to_cnt - TW'(1);
                    if (w_timeout) r_err <= ERR_TIMEOUT;
                end
                S_RX_ISSUE: if (!spi_busy) begin
                    r_spi_start <= 1'b1;
                    r_spi_tx    <= 8'h00;
                end
                S_RX_WAIT: if (spi_done) begin
                    r_result <= {r_result[8*BLOCK_BYTES-9:0], spi_rx};
                    r_rx_cnt <= r_rx_cnt - 5'd1;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_match <= r_cmp_en && (r_result == r_expected);
                end
                S_ERR: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign spi_start = r_spi_start;
    assign spi_tx    = r_spi_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign match     = r_match;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Directed bench for aes_spi_sequencer with a behavioural byte-SPI master and
// AES slave responder.
module tb_aes_spi_sequencer;

    logic         clk = 1'b0;
    logic         reset, req, mode, cmp_en;
    logic [1:0]   key_sel;
    logic [127:0] block_in, expected_in;
    logic [255:0] key_in;
    logic         spi_start, spi_busy, spi_done, res_ready;
    logic [7:0]   spi_tx, spi_rx;
    logic         busy, done, match;
    logic [127:0] result;
    logic [1:0]   err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // master/slave model state
    int           tid = 0, m_tid = 0;
    int           n_start = 0, m_cnt = 0, viol = 0, res_cnt = -1;
    int           cur_tx_len = 0, res_delay = 0, last_tx_cyc = 0, done_cyc = 0;
    logic         res_en = 1'b0;
    logic [127:0] slave_blk = '0, sq = '0;
    logic [7:0]   cur_byte = 8'h00;
    logic [7:0]   tx_log [80];

    localparam logic [127:0] BLK_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_128 = {128'hffffffffffffffffffffffffffffffff, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] KEY_192 = {64'hffffffffffffffff, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_spi_sequencer #(
        .BLOCK_BYTES   (16),
        .MAX_KEY_BYTES (32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mode       (mode),
        .key_sel    (key_sel),
        .block_in   (block_in),
        .key_in     (key_in),
        .expected_in(expected_in),
        .cmp_en     (cmp_en),
        .spi_start  (spi_start),
        .spi_tx     (spi_tx),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .spi_rx     (spi_rx),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .match      (match),
        .err        (err)
    );

    // Byte master: 3 busy cycles per byte, then a one-cycle done.
    initial begin
        spi_busy  = 1'b0;
        spi_done  = 1'b0;
        spi_rx    = 8'h00;
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (tid != m_tid) begin
                m_tid     = tid;
                n_start   = 0;
                res_ready = 1'b0;
                res_cnt   = -1;
                sq        = slave_blk;
            end
            if (reset) begin
                m_cnt    = 0;
                spi_busy = 1'b0;
                res_cnt  = -1;
            end else begin
                if (spi_start) begin
                    if (spi_busy || m_cnt != 0) viol++;
                    if (n_start < 80) tx_log[n_start] = spi_tx;
                    cur_byte = spi_tx;
                    n_start++;
                    spi_busy = 1'b1;
                    m_cnt    = 3;
                end else if (m_cnt != 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        spi_busy = 1'b0;
                        spi_done = 1'b1;
                        if (spi_tx != cur_byte) viol++;
                        if (n_start > cur_tx_len) begin
                            spi_rx = sq[127:120];
                            sq     = {sq[119:0], 8'h00};
                        end else begin
                            spi_rx = 8'h5a;
                        end
                        if (n_start == cur_tx_len) begin
                            last_tx_cyc = cyc;
                            if (res_en) res_cnt = res_delay;
                        end
                    end
                end
                if (res_cnt == 0) begin
                    res_ready = 1'b1;
                    res_cnt   = -1;
                end else if (res_cnt > 0) begin
                    res_cnt--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_block(input logic [1:0] ks, input logic md, input logic [127:0] blk,
                               input logic [255:0] key, input logic [127:0] expv, input logic ce,
                               input logic [127:0] slv, input int rdly, input logic ren, input int len);
        @(negedge clk);
        key_sel     = ks;
        mode        = md;
        block_in    = blk;
        key_in      = key;
        expected_in = expv;
        cmp_en      = ce;
        slave_blk   = slv;
        res_delay   = rdly;
        res_en      = ren;
        cur_tx_len  = len;
        tid         = tid + 1;
        req         = 1'b1;
        @(negedge clk);
        req         = 1'b0;
        block_in    = ~blk;
        key_in      = ~key;
        mode        = ~md;
        key_sel     = 2'b11;
        expected_in = ~expv;
    endtask

    task automatic finish_block(input string nm, input int busy_req_at, input int exp_starts,
                                input logic [7:0] exp_hdr, input logic [127:0] exp_res,
                                input logic exp_match, input logic [1:0] exp_err);
        int n = 0;
        chk({nm, "_busy_on"}, 128'(busy), 128'(1'b1));
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            req = (busy_req_at > 0) && (n == busy_req_at);
        end
        req = 1'b0;
        chk({nm, "_done_seen"}, 128'(done), 128'(1'b1));
        done_cyc = cyc;
        chk({nm, "_result"}, result, exp_res);
        chk({nm, "_match"}, 128'(match), 128'(exp_match));
        chk({nm, "_err"}, 128'(err), 128'(exp_err));
        chk({nm, "_busy_off"}, 128'(busy), 128'(1'b0));
        chk({nm, "_starts"}, 128'(n_start), 128'(exp_starts));
        chk({nm, "_header"}, 128'(tx_log[16]), 128'(exp_hdr));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 128'(done), 128'(1'b0));
    endtask

    initial begin
        int s0, n;
        logic [7:0] acc;
        logic       saw_ff;
        reset = 1'b1; req = 1'b0; mode = 1'b0; cmp_en = 1'b0; key_sel = 2'b00;
        block_in = '0; key_in = '0; expected_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_start", 128'(spi_start), 128'(1'b0));
        chk("rst_tx", 128'(spi_tx), 128'(8'h00));
        chk("rst_result", result, 128'h0);
        chk("rst_err", 128'(err), 128'(2'b00));
        reset = 1'b0;

        // AES-256 encrypt, result-ready already high on entry
        start_block(2'b10, 1'b0, BLK_A, KEY_256, CT_256, 1'b1, CT_256, 0, 1'b1, 49);
        finish_block("t1", 0, 65, 8'h20, CT_256, 1'b1, 2'b00);
        chk("t1_blk0", 128'(tx_log[0]), 128'(8'h00));
        chk("t1_blk15", 128'(tx_log[15]), 128'(8'hff));
        chk("t1_key0", 128'(tx_log[17]), 128'(8'h00));
        chk("t1_key31", 128'(tx_log[48]), 128'(8'h1f));
        acc = 8'h00;
        for (int i = 49; i < 65; i++) acc = acc | tx_log[i];
        chk("t1_dummy", 128'(acc), 128'(8'h00));

        // AES-128 encrypt, delayed result-ready, compare off
        start_block(2'b00, 1'b0, BLK_A, KEY_128, CT_128, 1'b0, CT_128, 5, 1'b1, 33);
        finish_block("t2", 0, 49, 8'h10, CT_128, 1'b0, 2'b00);
        chk("t2_key15", 128'(tx_log[32]), 128'(8'h0f));
        saw_ff = 1'b0;
        for (int i = 17; i < 33; i++) if (tx_log[i] == 8'hff) saw_ff = 1'b1;
        chk("t2_no_ff", 128'(saw_ff), 128'(1'b0));

        // AES-192 decrypt, with an ignored req while busy
        start_block(2'b01, 1'b1, CT_192, KEY_192, BLK_A, 1'b1, BLK_A, 2, 1'b1, 41);
        finish_block("t3", 20, 57, 8'h98, BLK_A, 1'b1, 2'b00);
        chk("t3_blk0", 128'(tx_log[0]), 128'(8'hdd));
        chk("t3_key0", 128'(tx_log[17]), 128'(8'h00));
        chk("t3_key23", 128'(tx_log[40]), 128'(8'h17));

        // illegal key size
        @(negedge clk);
        key_sel = 2'b11; req = 1'b1; s0 = n_start;
        @(negedge clk);
        req = 1'b0;
        chk("t4_done_early", 128'(done), 128'(1'b0));
        chk("t4_busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        chk("t4_done", 128'(done), 128'(1'b1));
        chk("t4_err", 128'(err), 128'(2'b01));
        chk("t4_result_kept", result, BLK_A);
        chk("t4_match", 128'(match), 128'(1'b0));
        @(negedge clk);
        chk("t4_done_pulse", 128'(done), 128'(1'b0));
        repeat (10) @(negedge clk);
        chk("t4_no_start", 128'(n_start), 128'(s0));

        // result-ready timeout
        start_block(2'b00, 1'b0, BLK_A, KEY_128, BLK_A, 1'b1, CT_128, 0, 1'b0, 33);
        finish_block("t5", 0, 33, 8'h10, BLK_A, 1'b0, 2'b10);
        chk("t5_timeout_cycles", 128'(done_cyc - last_tx_cyc), 128'(66));
        repeat (3) @(negedge clk);
        chk("t5_err_held", 128'(err), 128'(2'b10));

        // reset during TX byte 10
        start_block(2'b10, 1'b0, BLK_A, KEY_256, CT_256, 1'b1, CT_256, 0, 1'b1, 49);
        n = 0;
        while (n_start < 11 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_byte10", 128'(n_start), 128'(11));
        s0 = n_start;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", 128'(busy), 128'(1'b0));
        chk("t6_done", 128'(done), 128'(1'b0));
        chk("t6_start", 128'(spi_start), 128'(1'b0));
        chk("t6_tx", 128'(spi_tx), 128'(8'h00));
        chk("t6_result", result, 128'h0);
        chk("t6_match", 128'(match), 128'(1'b0));
        chk("t6_err", 128'(err), 128'(2'b00));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_start", 128'(n_start), 128'(s0));
        start_block(2'b10, 1'b0, BLK_A, KEY_256, CT_256, 1'b1, CT_256, 0, 1'b1, 49);
        finish_block("t6b", 0, 65, 8'h20, CT_256, 1'b1, 2'b00);

        // wrong slave data with compare enabled
        start_block(2'b10, 1'b0, BLK_A, KEY_256, CT_256, 1'b1,
                    128'h8ea2b7ca516745bfeafc49904b496088, 1, 1'b1, 49);
        finish_block("t7", 0, 65, 8'h20, 128'h8ea2b7ca516745bfeafc49904b496088, 1'b0, 2'b00);

        chk("protocol", 128'(viol), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
